// File: rtl/modulo_frequencimetro.sv
// rtl/modulo_frequencimetro.sv - gated frequency meter counting sig_in rising edges over a clk window
//
// Purpose: counts rising edges of the asynchronous input sig_in over a window
// of GATE_CYCLES clk cycles and publishes the result with a one-cycle done pulse.
//
// Parameters:
//   GATE_CYCLES  window length in clk cycles (1 .. 2^24-1)
//   CNT_W        width of the edge counter and of count
//
// Ports:
//   clk     in   system clock, rising-edge active
//   clr     in   asynchronous active-high reset
//   sig_in  in   signal to be measured, asynchronous to clk
//   start   in   single-cycle request to open a window
//   busy    out  high while a window is open
//   done    out  one-cycle pulse when count/ovf are updated
//   count   out  edges counted in the last completed window
//   ovf     out  last completed window saturated the counter
//
// Configuration macro: FREQ_CONTINUOUS_EN
//   defined   - after each done a new window reloads and starts immediately
//   undefined - single-shot, every window needs a start

module modulo_frequencimetro #(
    parameter int GATE_CYCLES = 1000,
    parameter int CNT_W       = 16
) (
    input  logic             clk,
    input  logic             clr,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic             done,
    output logic [CNT_W-1:0] count,
    output logic             ovf
);

    localparam int GATE_W = ($clog2(GATE_CYCLES + 1) < 1) ? 1 : $clog2(GATE_CYCLES + 1);
    localparam logic [GATE_W-1:0] GATE_LOAD = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    typedef enum logic {
        IDLE,
        MEASURE
    } state_t;

    state_t              state_q, state_d;
    logic                s1_q, s1_d, s2_q, s2_d, s3_q, s3_d;
    logic [CNT_W-1:0]    edge_cnt_q, edge_cnt_d;
    logic                ovf_int_q, ovf_int_d;
    logic [GATE_W-1:0]   gate_q, gate_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic [CNT_W-1:0]    count_q, count_d;
    logic                ovf_q, ovf_d;

    logic                sig_rise;
    logic                cnt_at_max;
    logic [CNT_W-1:0]    cnt_next;
    logic                ovf_next;

    always_comb begin
        state_d    = state_q;
        edge_cnt_d = edge_cnt_q;
        ovf_int_d  = ovf_int_q;
        gate_d     = gate_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        count_d    = count_q;
        ovf_d      = ovf_q;

        // s1 is the metastability catcher; the rise is detected between s2 and s3
        s1_d = sig_in;
        s2_d = s1_q;
        s3_d = s2_q;

        sig_rise   = s2_q & ~s3_q;
        cnt_at_max = (edge_cnt_q == CNT_MAX);
        cnt_next   = (sig_rise && !cnt_at_max) ? edge_cnt_q + 1'b1 : edge_cnt_q;
        ovf_next   = ovf_int_q | (sig_rise & cnt_at_max);

        case (state_q)
            IDLE: begin
                busy_d = 1'b0;
                if (start) begin
                    state_d    = MEASURE;
                    edge_cnt_d = '0;
                    ovf_int_d  = 1'b0;
                    gate_d     = GATE_LOAD;
                    busy_d     = 1'b1;
                end
            end
            MEASURE: begin
                busy_d     = 1'b1;
                edge_cnt_d = cnt_next;
                ovf_int_d  = ovf_next;
                gate_d     = gate_q - 1'b1;
                if (gate_q == '0) begin
                    // the edge seen on the closing cycle still belongs to this window
                    count_d = cnt_next;
                    ovf_d   = ovf_next;
                    done_d  = 1'b1;
                    busy_d  = 1'b0;
`ifdef FREQ_CONTINUOUS_EN
                    // reload in place so the next window starts with the done cycle
                    state_d    = MEASURE;
                    edge_cnt_d = '0;
                    ovf_int_d  = 1'b0;
                    gate_d     = GATE_LOAD;
`else
                    state_d    = IDLE;
`endif
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge clr) begin
        if (clr) begin
            state_q    <= IDLE;
            s1_q       <= 1'b0;
            s2_q       <= 1'b0;
            s3_q       <= 1'b0;
            edge_cnt_q <= '0;
            ovf_int_q  <= 1'b0;
            gate_q     <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            count_q    <= '0;
            ovf_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            s1_q       <= s1_d;
            s2_q       <= s2_d;
            s3_q       <= s3_d;
            edge_cnt_q <= edge_cnt_d;
            ovf_int_q  <= ovf_int_d;
            gate_q     <= gate_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            count_q    <= count_d;
            ovf_q      <= ovf_d;
        end
    end

    assign busy  = busy_q;
    assign done  = done_q;
    assign count = count_q;
    assign ovf   = ovf_q;

endmodule
